meta_array_nway: RTL

// - N-way per-set metadata store (valid/dirty/tag/LRU bits) for the L1 caches.
// - Registered read with 1-cycle latency; per-way write mask.
// - Multi-cycle flash-clear sequencer replaces single-cycle array reset, so the array can map to RAM.
// - Sits beside the data arrays; driven by the cache controller FSM.

---
 rtl/meta_array_nway_if.sv | 32 +++
 rtl/meta_array_nway.sv | 111 +++++++++++
 2 files changed

// File: rtl/meta_array_nway_if.sv
// Bus between the cache controller and the N-way metadata array.
//
// Command semantics: read, load and flush are single-cycle commands sampled at
// each rising clk edge. The array accepts them only while busy is 0; while
// busy is 1 they are dropped without any handshake. Results of a read appear
// on dataout one cycle after the command and remain until the next accepted
// read, a flush, or a reset.
interface meta_array_nway_if #(
  parameter int s_index  = 4,
  parameter int width    = 1,
  parameter int num_ways = 2
);
  logic                      read;
  logic [num_ways-1:0]       load;
  logic [s_index-1:0]        index;
  logic [width-1:0]          datain;
  logic                      flush;
  logic [num_ways*width-1:0] dataout;
  logic                      busy;

  // Cache controller side
  modport master (
    output read, load, index, datain, flush,
    input  dataout, busy
  );

  // Metadata array side
  modport slave (
    input  read, load, index, datain, flush,
    output dataout, busy
  );
endinterface

// File: rtl/meta_array_nway.sv
// N-way per-set metadata store (valid/dirty/tag/LRU bits) with a registered
// 1-cycle read, per-way write mask and a multi-cycle flash-clear sweep.
// The storage array has no reset so it can map onto RAM; the sweep is what
// initialises it after reset or flush.
// Optional build macro: META_ARRAY_NWAY_BYPASS_EN -- a read and load to the
// same set in the same cycle return the freshly written data for the loaded
// ways. Without it the read returns the pre-write contents.
module meta_array_nway #(
  parameter int                s_index  = 4,
  parameter int                width    = 1,
  parameter int                num_ways = 2,
  parameter logic [width-1:0]  init_val = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  meta_array_nway_if.slave     bus
);

  localparam int num_sets = 1 << s_index;
  // Terminal sweep count; the counter carries one spare bit and never wraps.
  localparam logic [s_index:0] last_set = {1'b0, {s_index{1'b1}}};

  // busy is exactly (state == CLEAR), so it doubles as the state observation.
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                    state, state_next;
  logic [s_index:0]          count, count_next;
  logic                      clr_we;
  logic [num_ways-1:0]       way_we;
  logic                      rd_en;
  logic                      zero_out;
  logic [num_ways*width-1:0] rd_data;

  logic [width-1:0] mem [num_sets][num_ways];

  assign bus.busy = (state == CLEAR);

  // State and sweep counter register; reset restarts the sweep from set 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic and per-cycle strobes for storage and output register.
  always_comb begin
    state_next = state;
    count_next = count;
    clr_we     = 1'b0;
    way_we     = '0;
    rd_en      = 1'b0;
    zero_out   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we     = 1'b1;
        zero_out   = 1'b1;
        count_next = count + 1'b1;
        if (count == last_set) state_next = IDLE;
      end
      IDLE: begin
        if (bus.flush) begin
          // Flush wins over any same-cycle read or load.
          state_next = CLEAR;
          count_next = '0;
          zero_out   = 1'b1;
        end else begin
          way_we = bus.load;
          rd_en  = bus.read;
        end
      end
      default: begin
        state_next = CLEAR;
        count_next = '0;
      end
    endcase
  end

  // Storage write port: sweep writes all ways of one set, else masked load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < num_ways; w++) begin
        if (clr_we) mem[count[s_index-1:0]][w] <= init_val;
        else if (way_we[w]) mem[bus.index][w] <= bus.datain;
      end
    end
  end

  // Read data for the addressed set, optionally forwarding same-cycle writes.
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < num_ways; w++) begin
`ifdef META_ARRAY_NWAY_BYPASS_EN
      if (way_we[w]) rd_data[w*width +: width] = bus.datain;
      else           rd_data[w*width +: width] = mem[bus.index][w];
`else
      rd_data[w*width +: width] = mem[bus.index][w];
`endif
    end
  end

  // Registered read output; forced to zero during reset and the clear sweep.
  always_ff @(posedge clk) begin
    if (rst || zero_out) bus.dataout <= '0;
    else if (rd_en)      bus.dataout <= rd_data;
  end

endmodule
